// File: rtl/gray_step_ctrl_pkg.sv
// Shared types and constants for the gray step controller.
// State encoding, gray wrap point, wrap-counter saturation and the gray successor table.
package gray_step_ctrl_pkg;

   localparam int GRAY_W = 3;
   localparam int REM_W  = 5;
   localparam int WCNT_W = 4;

   localparam logic [GRAY_W-1:0] GRAY_WRAP = 3'd4;
   localparam logic [WCNT_W-1:0] WRAP_SAT  = 4'd15;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Successor in the cycle 0,1,3,2,6,7,5,4,0.
   function automatic logic [GRAY_W-1:0] gray_next(input logic [GRAY_W-1:0] g);
      logic [GRAY_W-1:0] n;
      case (g)
         3'd0:    n = 3'd1;
         3'd1:    n = 3'd3;
         3'd3:    n = 3'd2;
         3'd2:    n = 3'd6;
         3'd6:    n = 3'd7;
         3'd7:    n = 3'd5;
         3'd5:    n = 3'd4;
         default: n = 3'd0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/gray_step_ctrl_core.sv
// Gray value register: advances one step when enabled and flags the 4->0 wrap.
// Module gray_step_core; the value persists across runs and is cleared only by reset.
module gray_step_core
   import gray_step_ctrl_pkg::*;
(
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              en_i,
   output logic [GRAY_W-1:0] gray_o,
   output logic              wrap_o
);

   // NOTE: the declaration initializer gives the power-up value; reset still sets it explicitly.
   logic [GRAY_W-1:0] gray_q = '0;
   logic [GRAY_W-1:0] gray_d;

   always_comb begin
      gray_d = en_i ? gray_next(gray_q) : gray_q;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (reset_i) gray_q <= '0;
      else         gray_q <= gray_d;
   end

   assign gray_o = gray_q;
   assign wrap_o = en_i && (gray_q == GRAY_WRAP);

endmodule

// File: rtl/gray_step_ctrl.sv
// Run controller stepping a 3-bit gray value a programmed number of times.
// Macro GRAY_STEP_CTRL_WRAPCNT_EN builds the saturating wrap counter; otherwise WrapCount is tied to 0.
module gray_step_ctrl
   import gray_step_ctrl_pkg::*;
(
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Start,
   input  logic [REM_W-1:0]  Steps,
   input  logic              Hold,
   input  logic              Stop,
   output logic              Busy,
   output logic              Done,
   output logic [GRAY_W-1:0] Gray,
   output logic              Overflow,
   output logic [WCNT_W-1:0] WrapCount
);

   state_t            state_q = ST_IDLE;
   state_t            state_d;
   logic [REM_W-1:0]  rem_q   = '0;
   logic [REM_W-1:0]  rem_d;
   logic              ovf_q   = 1'b0;
   logic              adv;
   logic              wrap;

   gray_step_core u_core (
      .clk_i   (Clk),
      .reset_i (Reset),
      .en_i    (adv),
      .gray_o  (Gray),
      .wrap_o  (wrap)
   );

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      adv     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (Start) begin
               if (Steps != '0) begin
                  rem_d   = Steps;
                  state_d = ST_RUN;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_RUN: begin
            // Stop outranks Hold and aborts without an advance or a Done pulse.
            if (Stop) begin
               state_d = ST_IDLE;
            end else if (!Hold) begin
               adv   = 1'b1;
               rem_d = rem_q - 5'd1;
               if (rem_q == 5'd1) state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= ST_IDLE;
         rem_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         if (wrap) ovf_q <= 1'b1;
      end
   end

`ifdef GRAY_STEP_CTRL_WRAPCNT_EN
   logic [WCNT_W-1:0] wcnt_q = '0;

   always_ff @(posedge Clk) begin
      if (Reset)                         wcnt_q <= '0;
      else if (wrap && wcnt_q != WRAP_SAT) wcnt_q <= wcnt_q + 4'd1;
   end

   assign WrapCount = wcnt_q;
`else
   assign WrapCount = '0;
`endif

   assign Busy     = (state_q == ST_RUN);
   assign Done     = (state_q == ST_DONE);
   assign Overflow = ovf_q;

endmodule

// File: tb/tb_gray_step_ctrl.sv
// Directed, self-checking bench for gray_step_ctrl.
// Honours GRAY_STEP_CTRL_WRAPCNT_EN when choosing expected WrapCount values.
module tb_gray_step_ctrl;

   logic       Clk = 1'b0;
   logic       Reset = 1'b0;
   logic       Start = 1'b0;
   logic [4:0] Steps = '0;
   logic       Hold = 1'b0;
   logic       Stop = 1'b0;
   logic       Busy;
   logic       Done;
   logic [2:0] Gray;
   logic       Overflow;
   logic [3:0] WrapCount;

   int errors = 0;
   int checks = 0;

`ifdef GRAY_STEP_CTRL_WRAPCNT_EN
   localparam bit WC_EN = 1'b1;
`else
   localparam bit WC_EN = 1'b0;
`endif

   gray_step_ctrl dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .Start     (Start),
      .Steps     (Steps),
      .Hold      (Hold),
      .Stop      (Stop),
      .Busy      (Busy),
      .Done      (Done),
      .Gray      (Gray),
      .Overflow  (Overflow),
      .WrapCount (WrapCount)
   );

   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
   endtask

   task automatic test_reset();
      checks++;
      if ({Gray, Busy, Done, Overflow, WrapCount} !== 10'd0) begin
         errors++;
         $display("FAIL powerup: got gray=%0d busy=%0b done=%0b ovf=%0b wc=%0d, want all 0",
                  Gray, Busy, Done, Overflow, WrapCount);
      end
      Start = 1'b1; Steps = 5'd3;
      Reset = 1'b1;
      tick();
      Reset = 1'b0; Start = 1'b0;
      checks++;
      if ({Gray, Busy, Done, Overflow, WrapCount} !== 10'd0) begin
         errors++;
         $display("FAIL reset: got gray=%0d busy=%0b done=%0b ovf=%0b wc=%0d, want all 0",
                  Gray, Busy, Done, Overflow, WrapCount);
      end
   endtask

   task automatic test_steps3();
      logic [2:0] exp_gray [4] = '{3'd0, 3'd1, 3'd3, 3'd2};
      logic       exp_busy [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      logic       exp_done [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      do_reset();
      Start = 1'b1; Steps = 5'd3;
      for (int i = 0; i < 4; i++) begin
         tick();
         Start = 1'b0;
         checks++;
         if (Gray !== exp_gray[i] || Busy !== exp_busy[i] || Done !== exp_done[i]) begin
            errors++;
            $display("FAIL steps3[%0d]: got gray=%0d busy=%0b done=%0b, want gray=%0d busy=%0b done=%0b",
                     i, Gray, Busy, Done, exp_gray[i], exp_busy[i], exp_done[i]);
         end
      end
      tick();
      checks++;
      if (Done !== 1'b0 || Busy !== 1'b0 || Overflow !== 1'b0) begin
         errors++;
         $display("FAIL steps3_end: got done=%0b busy=%0b ovf=%0b, want 0 0 0", Done, Busy, Overflow);
      end
   endtask

   task automatic test_wrap8();
      logic [2:0] seq [8] = '{3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4, 3'd0};
      do_reset();
      Start = 1'b1; Steps = 5'd8;
      tick();
      Start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         checks++;
         if (Gray !== seq[i]) begin
            errors++;
            $display("FAIL wrap8_seq[%0d]: got gray=%0d, want %0d", i, Gray, seq[i]);
         end
         if (i == 6) begin
            checks++;
            if (Overflow !== 1'b0) begin
               errors++;
               $display("FAIL wrap8_preovf: got ovf=%0b, want 0", Overflow);
            end
         end
      end
      checks++;
      if (Done !== 1'b1 || Overflow !== 1'b1 || WrapCount !== (WC_EN ? 4'd1 : 4'd0)) begin
         errors++;
         $display("FAIL wrap8_end: got done=%0b ovf=%0b wc=%0d, want 1 1 %0d",
                  Done, Overflow, WrapCount, WC_EN ? 1 : 0);
      end
      tick();
   endtask

   task automatic test_hold();
      logic       hold_v   [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      logic [2:0] exp_gray [7] = '{3'd1, 3'd3, 3'd3, 3'd3, 3'd2, 3'd6, 3'd7};
      logic       exp_busy [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      logic       exp_done [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      do_reset();
      Start = 1'b1; Steps = 5'd5;
      tick();
      Start = 1'b0;
      for (int i = 0; i < 7; i++) begin
         Hold = hold_v[i];
         tick();
         checks++;
         if (Gray !== exp_gray[i] || Busy !== exp_busy[i] || Done !== exp_done[i]) begin
            errors++;
            $display("FAIL hold[%0d]: got gray=%0d busy=%0b done=%0b, want gray=%0d busy=%0b done=%0b",
                     i, Gray, Busy, Done, exp_gray[i], exp_busy[i], exp_done[i]);
         end
      end
      Hold = 1'b0;
      tick();
   endtask

   task automatic test_stop();
      do_reset();
      Start = 1'b1; Steps = 5'd6;
      tick();
      Start = 1'b0;
      tick();
      tick();
      checks++;
      if (Gray !== 3'd3 || Busy !== 1'b1) begin
         errors++;
         $display("FAIL stop_pre: got gray=%0d busy=%0b, want 3 1", Gray, Busy);
      end
      Stop = 1'b1; Hold = 1'b1;
      tick();
      Stop = 1'b0; Hold = 1'b0;
      checks++;
      if (Gray !== 3'd3 || Busy !== 1'b0 || Done !== 1'b0) begin
         errors++;
         $display("FAIL stop_edge: got gray=%0d busy=%0b done=%0b, want 3 0 0", Gray, Busy, Done);
      end
      tick();
      checks++;
      if (Gray !== 3'd3 || Busy !== 1'b0 || Done !== 1'b0) begin
         errors++;
         $display("FAIL stop_after: got gray=%0d busy=%0b done=%0b, want 3 0 0", Gray, Busy, Done);
      end
      Start = 1'b1; Steps = 5'd1;
      tick();
      Start = 1'b0;
      tick();
      checks++;
      if (Gray !== 3'd2 || Done !== 1'b1) begin
         errors++;
         $display("FAIL stop_rerun: got gray=%0d done=%0b, want 2 1", Gray, Done);
      end
      tick();
   endtask

   // Starts with Gray=2 left by test_stop.
   task automatic test_zero();
      Start = 1'b1; Steps = 5'd0;
      tick();
      Start = 1'b0;
      checks++;
      if (Done !== 1'b1 || Busy !== 1'b0 || Gray !== 3'd2) begin
         errors++;
         $display("FAIL zero_done: got done=%0b busy=%0b gray=%0d, want 1 0 2", Done, Busy, Gray);
      end
      tick();
      checks++;
      if (Done !== 1'b0 || Busy !== 1'b0 || Gray !== 3'd2) begin
         errors++;
         $display("FAIL zero_after: got done=%0b busy=%0b gray=%0d, want 0 0 2", Done, Busy, Gray);
      end
      Start = 1'b1; Steps = 5'd2;
      tick();
      Steps = 5'd7;
      tick();
      checks++;
      if (Gray !== 3'd6 || Busy !== 1'b1) begin
         errors++;
         $display("FAIL start_in_run: got gray=%0d busy=%0b, want 6 1", Gray, Busy);
      end
      tick();
      checks++;
      if (Gray !== 3'd7 || Done !== 1'b1) begin
         errors++;
         $display("FAIL start_in_run_done: got gray=%0d done=%0b, want 7 1", Gray, Done);
      end
      tick();
      Start = 1'b0;
      checks++;
      if (Busy !== 1'b0 || Done !== 1'b0 || Gray !== 3'd7) begin
         errors++;
         $display("FAIL start_in_done: got busy=%0b done=%0b gray=%0d, want 0 0 7", Busy, Done, Gray);
      end
   endtask

   task automatic test_reset_mid_run();
      do_reset();
      Start = 1'b1; Steps = 5'd8;
      tick();
      Start = 1'b0;
      for (int i = 0; i < 9; i++) tick();
      Start = 1'b1; Steps = 5'd5;
      tick();
      Start = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      checks++;
      if (Gray !== 3'd6 || Busy !== 1'b1 || Overflow !== 1'b1) begin
         errors++;
         $display("FAIL rst_run_pre: got gray=%0d busy=%0b ovf=%0b, want 6 1 1", Gray, Busy, Overflow);
      end
      Reset = 1'b1; Start = 1'b1; Hold = 1'b1;
      tick();
      Reset = 1'b0; Start = 1'b0; Hold = 1'b0;
      checks++;
      if ({Gray, Busy, Done, Overflow, WrapCount} !== 10'd0) begin
         errors++;
         $display("FAIL rst_run: got gray=%0d busy=%0b done=%0b ovf=%0b wc=%0d, want all 0",
                  Gray, Busy, Done, Overflow, WrapCount);
      end
   endtask

   task automatic test_saturation();
      logic [3:0] exp_wc;
      do_reset();
      for (int r = 1; r <= 17; r++) begin
         Start = 1'b1; Steps = 5'd8;
         tick();
         Start = 1'b0;
         for (int c = 0; c < 20 && Done !== 1'b1; c++) tick();
         exp_wc = WC_EN ? ((r > 15) ? 4'd15 : 4'(r)) : 4'd0;
         checks++;
         if (Done !== 1'b1 || Gray !== 3'd0 || WrapCount !== exp_wc) begin
            errors++;
            $display("FAIL sat_run%0d: got done=%0b gray=%0d wc=%0d, want 1 0 %0d",
                     r, Done, Gray, WrapCount, exp_wc);
         end
         tick();
      end
   endtask

   initial begin
      #1;
      test_reset();
      test_steps3();
      test_wrap8();
      test_hold();
      test_stop();
      test_zero();
      test_reset_mid_run();
      test_saturation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
